uart_rx_fifo: RTL and testbench

Receive buffer between `uart_rx` and the UART register file. Captures each character (data plus parity/frame/break flags) on `rx_valid` into a 16-entry show-ahead FIFO and presents the head entry for RBR reads. Generates 16550-style status for the interrupt and LSR logic: data ready, overrun, FIFO error, trigger level reached, and character timeout. Supports non-FIFO mode, where the buffer acts as a single holding register.

---
 rtl/uart_rx_fifo.sv | 156 +++++++++++++++
 tb/tb_uart_rx_fifo.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: receive buffer between uart_rx and the UART register file.
// Each received character and its error flags are stored in a show-ahead FIFO.
// The block also produces the 16550-style receive status.
//
// Ports
//   clk_i, rst_n_i        clock; asynchronous active-low reset
//   div_clk_en_i          16x baud tick, used by the character timeout
//   rx_valid_i/_data_i/_err_i  character strobe, data and flags from uart_rx
//   pop_i                 RBR read strobe
//   lsr_read_i            LSR read strobe; clears overrun
//   clr_fifo_i            synchronous flush
//   cfg_*_i               FIFO enable, trigger level, word length, parity enable
//   rd_data_o/rd_err_o    head entry (zero when empty)
//   data_ready_o, count_o, overrun_o, fifo_err_o, trigger_o, timeout_o  status
package uart_pkg;
    typedef enum logic [1:0] {WL5 = 2'd0, WL6 = 2'd1, WL7 = 2'd2, WL8 = 2'd3} word_len_e;
    typedef struct packed {
        logic break_int;
        logic frame_err;
        logic parity_err;
    } rx_err_s;
endpackage

module uart_rx_fifo #(
    parameter int DEPTH = 16
) (
    input  logic                      clk_i,
    input  logic                      rst_n_i,
    input  logic                      div_clk_en_i,
    input  logic                      rx_valid_i,
    input  logic [7:0]                rx_data_i,
    input  uart_pkg::rx_err_s         rx_err_i,
    input  logic                      pop_i,
    input  logic                      lsr_read_i,
    input  logic                      clr_fifo_i,
    input  logic                      cfg_fifo_en_i,
    input  logic [1:0]                cfg_trig_lvl_i,
    input  uart_pkg::word_len_e       cfg_word_len_i,
    input  logic                      cfg_parity_en_i,
    output logic [7:0]                rd_data_o,
    output uart_pkg::rx_err_s         rd_err_o,
    output logic                      data_ready_o,
    output logic [$clog2(DEPTH):0]    count_o,
    output logic                      overrun_o,
    output logic                      fifo_err_o,
    output logic                      trigger_o,
    output logic                      timeout_o
);
    localparam int AW = $clog2(DEPTH);

    logic [10:0] mem_q [DEPTH];
    logic [AW:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0] flag_cnt_q, flag_cnt_d;
    logic [9:0]  to_cnt_q, to_cnt_d;
    logic        overrun_q, overrun_d;
    logic        fifo_en_q;

    logic [AW-1:0] wr_idx, rd_idx;
    logic [AW:0]   count;
    logic          empty, full, clr, push_ok, pop_ok, lost, ovw;
    logic          new_flag, head_flag;
    logic [10:0]   head;
    logic [3:0]    frame_bits;
    logic [9:0]    to_thr;
    logic [4:0]    trig_thr;

    assign wr_idx = wr_ptr_q[AW-1:0];
    assign rd_idx = rd_ptr_q[AW-1:0];
    assign count  = wr_ptr_q - rd_ptr_q;
    assign empty  = (wr_ptr_q == rd_ptr_q);
    // Non-FIFO mode has an effective depth of one entry.
    assign full   = cfg_fifo_en_i ? ((wr_idx == rd_idx) && (wr_ptr_q[AW] != rd_ptr_q[AW]))
                                  : !empty;
    assign head   = mem_q[rd_idx];

    // A change of FIFO mode flushes the buffer just like clr_fifo.
    assign clr       = clr_fifo_i || (cfg_fifo_en_i != fifo_en_q);
    assign pop_ok    = pop_i && !empty && !clr;
    assign push_ok   = rx_valid_i && !clr && (!full || pop_i);
    assign lost      = rx_valid_i && !clr && full && !pop_i;
    // In non-FIFO mode a lost character replaces the held one instead of being dropped.
    assign ovw       = lost && !cfg_fifo_en_i;
    assign new_flag  = |rx_err_i;
    assign head_flag = |head[10:8];

    // Character time in 16x ticks is 16*F; four characters is 64*F.
    assign frame_bits = 4'd7 + {2'b00, cfg_word_len_i} + {3'b000, cfg_parity_en_i};
    assign to_thr     = {frame_bits, 6'b000000};

    always_comb begin
        case (cfg_trig_lvl_i)
            2'd0:    trig_thr = 5'd1;
            2'd1:    trig_thr = 5'd4;
            2'd2:    trig_thr = 5'd8;
            default: trig_thr = 5'd14;
        endcase
    end

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        flag_cnt_d = flag_cnt_q;
        to_cnt_d   = to_cnt_q;
        overrun_d  = overrun_q;
        if (clr) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            flag_cnt_d = '0;
        end else begin
            if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
            flag_cnt_d = flag_cnt_q + (AW+1)'((push_ok || ovw) && new_flag)
                                    - (AW+1)'((pop_ok || ovw) && head_flag);
        end
        if (clr || push_ok || pop_ok || empty || !cfg_fifo_en_i)
            to_cnt_d = '0;
        else if (div_clk_en_i && (to_cnt_q < to_thr))
            to_cnt_d = to_cnt_q + 10'd1;
        // Set has priority over the LSR read clear.
        if (lost)            overrun_d = 1'b1;
        else if (lsr_read_i) overrun_d = 1'b0;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            flag_cnt_q <= '0;
            to_cnt_q   <= '0;
            overrun_q  <= 1'b0;
            fifo_en_q  <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            flag_cnt_q <= flag_cnt_d;
            to_cnt_q   <= to_cnt_d;
            overrun_q  <= overrun_d;
            fifo_en_q  <= cfg_fifo_en_i;
        end
    end

    // Storage is not reset; outputs are masked while empty.
    always_ff @(posedge clk_i) begin
        if (push_ok)  mem_q[wr_idx] <= {rx_err_i, rx_data_i};
        else if (ovw) mem_q[rd_idx] <= {rx_err_i, rx_data_i};
    end

    assign rd_data_o    = empty ? 8'h00 : head[7:0];
    assign rd_err_o     = empty ? '0 : uart_pkg::rx_err_s'(head[10:8]);
    assign data_ready_o = !empty;
    assign count_o      = count;
    assign overrun_o    = overrun_q;
    assign fifo_err_o   = (flag_cnt_q != '0);
    assign trigger_o    = cfg_fifo_en_i && ({{(8-AW-1){1'b0}}, count} >= {3'b000, trig_thr});
    assign timeout_o    = cfg_fifo_en_i && !empty && (to_cnt_q == to_thr);
endmodule

// File: tb/tb_uart_rx_fifo.sv
module tb_uart_rx_fifo;
    import uart_pkg::*;

    logic clk = 1'b0, rst_n = 1'b0;
    logic div_clk_en = 0, rx_valid = 0, pop = 0, lsr_read = 0, clr_fifo = 0;
    logic [7:0] rx_data = 0;
    rx_err_s rx_err = '0;
    logic cfg_fifo_en = 1, cfg_parity_en = 0;
    logic [1:0] cfg_trig_lvl = 0;
    word_len_e cfg_word_len = WL8;
    logic [7:0] rd_data;
    rx_err_s rd_err;
    logic data_ready, overrun, fifo_err, trigger, timeout;
    logic [4:0] count;

    int errors = 0, checks = 0;
    logic [10:0] exp_q[$];

    uart_rx_fifo #(.DEPTH(16)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .div_clk_en_i(div_clk_en),
        .rx_valid_i(rx_valid), .rx_data_i(rx_data), .rx_err_i(rx_err),
        .pop_i(pop), .lsr_read_i(lsr_read), .clr_fifo_i(clr_fifo),
        .cfg_fifo_en_i(cfg_fifo_en), .cfg_trig_lvl_i(cfg_trig_lvl),
        .cfg_word_len_i(cfg_word_len), .cfg_parity_en_i(cfg_parity_en),
        .rd_data_o(rd_data), .rd_err_o(rd_err), .data_ready_o(data_ready),
        .count_o(count), .overrun_o(overrun), .fifo_err_o(fifo_err),
        .trigger_o(trigger), .timeout_o(timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every RBR read is compared against the scoreboard head.
    always @(negedge clk) begin
        if (rst_n && pop) begin
            if (exp_q.size() > 0) begin
                logic [10:0] e;
                e = exp_q.pop_front();
                chk("rbr_data", {24'h0, rd_data}, {24'h0, e[7:0]});
                chk("rbr_err", {29'h0, rd_err}, {29'h0, e[10:8]});
            end else begin
                chk("rbr_empty_ready", {31'h0, data_ready}, 32'h0);
            end
        end
    end

    task automatic cyc();
        @(posedge clk); #1;
    endtask

    // keep=1: the character is expected to be stored.
    task automatic push(input logic [7:0] d, input logic [2:0] e, input bit keep);
        rx_valid = 1; rx_data = d; rx_err = rx_err_s'(e);
        if (keep) exp_q.push_back({e, d});
        cyc();
        rx_valid = 0; rx_err = '0;
    endtask

    task automatic do_pop();
        pop = 1; cyc(); pop = 0;
    endtask

    task automatic do_clr();
        clr_fifo = 1; exp_q.delete(); cyc(); clr_fifo = 0;
    endtask

    initial begin
        #12;
        chk("rst_count", {27'h0, count}, 0);
        chk("rst_ready", {31'h0, data_ready}, 0);
        chk("rst_rd_data", {24'h0, rd_data}, 0);
        chk("rst_flags", {26'h0, overrun, fifo_err, trigger, timeout, rd_err != 3'b0, 1'b0}, 0);
        rst_n = 1;
        cyc(); cyc();

        // Fill, overflow, drain in order.
        for (int i = 0; i < 16; i++) push(8'h41 + 8'(i), 3'b000, 1);
        push(8'h51, 3'b000, 0);
        chk("full_count", {27'h0, count}, 16);
        chk("full_overrun", {31'h0, overrun}, 1);
        for (int i = 0; i < 16; i++) do_pop();
        chk("drain_count", {27'h0, count}, 0);
        chk("overrun_sticky", {31'h0, overrun}, 1);
        lsr_read = 1; cyc(); lsr_read = 0;
        chk("overrun_cleared", {31'h0, overrun}, 0);

        // Full with push+pop in the same cycle.
        for (int i = 0; i < 16; i++) push(8'h60 + 8'(i), 3'b000, 1);
        pop = 1; push(8'h70, 3'b000, 1); pop = 0;
        chk("pp_count", {27'h0, count}, 16);
        chk("pp_no_overrun", {31'h0, overrun}, 0);
        chk("pp_head", {24'h0, rd_data}, 32'h61);
        // Clear coinciding with a character: clear wins.
        clr_fifo = 1; exp_q.delete(); push(8'h99, 3'b000, 0); clr_fifo = 0;
        chk("clr_count", {27'h0, count}, 0);
        chk("clr_ready", {31'h0, data_ready}, 0);

        // Trigger level 8.
        cfg_trig_lvl = 2'd2;
        for (int i = 0; i < 7; i++) push(8'h30 + 8'(i), 3'b000, 1);
        chk("trig_7", {31'h0, trigger}, 0);
        push(8'h37, 3'b000, 1);
        chk("trig_8", {31'h0, trigger}, 1);
        do_pop();
        chk("trig_after_pop", {31'h0, trigger}, 0);
        do_clr();
        cfg_trig_lvl = 2'd0;

        // Error flag accounting.
        push(8'h55, 3'b001, 1);
        for (int i = 0; i < 3; i++) push(8'h01 + 8'(i), 3'b000, 1);
        chk("ferr_set", {31'h0, fifo_err}, 1);
        chk("head_parity", {31'h0, rd_err.parity_err}, 1);
        do_pop();
        chk("ferr_clear", {31'h0, fifo_err}, 0);
        do_clr();

        // Timeout: 8N1, F=10, threshold 640 ticks.
        push(8'hA5, 3'b000, 1);
        for (int k = 1; k <= 640; k++) begin
            div_clk_en = 1; cyc(); div_clk_en = 0;
            if (k == 639) chk("to_639", {31'h0, timeout}, 0);
            if (k == 640) chk("to_640", {31'h0, timeout}, 1);
            cyc();
        end
        chk("to_held", {31'h0, timeout}, 1);
        do_pop();
        chk("to_after_pop", {31'h0, timeout}, 0);
        chk("to_ready", {31'h0, data_ready}, 0);

        // Non-FIFO holding register overwrite.
        cfg_fifo_en = 0; exp_q.delete(); cyc(); cyc();
        push(8'h11, 3'b000, 1);
        void'(exp_q.pop_back());
        push(8'h22, 3'b000, 1);
        chk("nf_data", {24'h0, rd_data}, 32'h22);
        chk("nf_count", {27'h0, count}, 1);
        chk("nf_overrun", {31'h0, overrun}, 1);
        do_pop();
        chk("nf_empty", {31'h0, data_ready}, 0);

        // Asynchronous reset mid-stream.
        cfg_fifo_en = 1; cyc(); cyc();
        push(8'h0F, 3'b010, 1);
        push(8'h1F, 3'b000, 1);
        #2 rst_n = 0; exp_q.delete();
        #1;
        chk("arst_count", {27'h0, count}, 0);
        chk("arst_data", {24'h0, rd_data}, 0);
        chk("arst_flags", {27'h0, data_ready, overrun, fifo_err, rd_err != 3'b0, timeout}, 0);
        cyc();
        rst_n = 1;
        cyc();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
